toggle_period_meter: RTL
========================

Name: toggle_period_meter

Overview:
Receive-side counterpart of the team's toggle generator. Samples an asynchronous toggling input and measures the number of i_clk cycles between consecutive transitions. Reports each measured half-period with a one-cycle valid strobe and flags a timeout when no transition arrives within a limit. Used in the memory-game design to check blink/tone timing and for self-test of toggle generators.

Parameters:
MAX_COUNT, 1000, timeout limit in cycles; largest reportable period; must be >= 2
SYNC_STAGES, 2, synchronizer depth on i_toggle; must be >= 2
W (localparam), $clog2(MAX_COUNT+1), width of the period counter and outputs

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_enable  in  1  measurement enable; low forces IDLE
i_toggle  in  1  asynchronous toggling input under measurement
o_period  out  W  last measured period in cycles; holds until next valid measurement
o_valid  out  1  one-cycle strobe; o_period updated this cycle
o_timeout  out  1  one-cycle strobe; no edge within MAX_COUNT cycles
o_measuring  out  1  high while in MEASURE state

Behaviour:
- Reset (async, i_rst=1): state IDLE, counter 0, sync chain all 0, edge-history flop 0; o_period=0, o_valid=0, o_timeout=0, o_measuring=0. Reset mid-measurement discards the measurement in progress with no strobe.
- Sync: i_toggle passes through SYNC_STAGES flops; edge = sync_out XOR previous sync_out (either polarity). The history flop updates in every state, so a level present at enable does not count as an edge.
- States: IDLE, ARMED, MEASURE.
- IDLE: counter held at 0. If i_enable=1, go to ARMED next cycle.
- ARMED: waiting for the first edge. On edge, go to MEASURE with counter<=1 and no strobe.
- MEASURE: counter increments by 1 each cycle with no edge.
  - On edge: o_period<=counter, o_valid=1 for one cycle, counter<=1, stay in MEASURE.
  - If counter==MAX_COUNT with no edge: o_timeout=1 for one cycle, counter<=0, go to ARMED. The next edge restarts measurement and produces no o_valid.
  - Edge in the same cycle as counter==MAX_COUNT: the edge wins. o_period=MAX_COUNT, o_valid=1, no timeout.
- i_enable=0 in any state: go to IDLE next cycle, no strobes, counter<=0, o_period holds its last value.
- o_valid and o_timeout are never high in the same cycle. Both are registered.
- Measured value: a generator toggling every N cycles yields o_period=N.
- Latency: o_valid rises SYNC_STAGES+1 cycles after the i_clk edge that samples the i_toggle change.
- No counter wrap: the counter saturates at MAX_COUNT through the timeout path.
- o_measuring = (state==MEASURE), registered with the state.

Optional Feature:
Macro: TOGGLE_PERIOD_METER_MINMAX_EN.
- Defined: adds outputs o_min_period and o_max_period, each W bits.
  - Both update in the same cycle as each o_valid.
  - Both clear on reset and on any i_enable 0->1 transition (o_min to all-ones, o_max to 0).
  - The first valid measurement after clearing sets both outputs.
  - Timeouts do not affect either output.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package toggle_meter_pkg: state enum typedef (IDLE, ARMED, MEASURE); width helper function for W.
- Sub-module sync_edge_detect (params STAGES): synchronizer chain plus history flop. Outputs o_level and o_edge, with async reset on i_rst.
- The FSM, counter and outputs stay in the top module.

Test Plan:
All scenarios use MAX_COUNT=16, SYNC_STAGES=2 unless stated.
1. Reset: assert i_rst mid-MEASURE with counter=7 -> all outputs 0 immediately (async), state IDLE, no strobe after release.
2. Enable, then toggle i_toggle every 10 cycles for 5 edges -> first edge gives no strobe; then 4 o_valid pulses, each with o_period=10, spaced 10 cycles apart, latency 3 cycles after each input change.
3. One edge, then hold i_toggle for 20 cycles -> o_timeout pulses once, 16 cycles after the edge is detected. The next edge gives no o_valid; a following edge 5 cycles later gives o_period=5.
4. Edges exactly 16 cycles apart -> o_valid with o_period=16, o_timeout never asserted.
5. Drop i_enable mid-MEASURE, toggle during disable, re-enable -> no strobes while disabled, o_period holds its old value, first edge after re-enable gives no strobe.
6. With TOGGLE_PERIOD_METER_MINMAX_EN defined, periods 8, 12, 5 -> after the last: o_min_period=5, o_max_period=12. After re-enable both clear, and the next period 9 gives min=max=9.

Source files
------------

// File: rtl/toggle_meter_pkg.sv
// Shared types for the toggle period meter: FSM state encoding and the
// counter width helper.
package toggle_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain for an asynchronous input followed by a history flop;
// o_edge is a registered pulse for a level change of either polarity.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_toggle,
  output logic o_level,
  output logic o_edge
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      o_edge <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_toggle};
      hist_q <= sync_q[STAGES-1];
      o_edge <= sync_q[STAGES-1] ^ hist_q;
    end
  end

  assign o_level = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_period_meter.sv
// Measures i_clk cycles between transitions of an asynchronous toggle input.
// Optional min/max tracking is enabled with `define TOGGLE_PERIOD_METER_MINMAX_EN.
module toggle_period_meter
  import toggle_meter_pkg::*;
#(
  parameter  int MAX_COUNT   = 1000,
  parameter  int SYNC_STAGES = 2,
  localparam int W           = count_width(MAX_COUNT)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_enable,
  input  logic         i_toggle,
  output logic [W-1:0] o_period,
  output logic         o_valid,
  output logic         o_timeout,
`ifdef TOGGLE_PERIOD_METER_MINMAX_EN
  output logic [W-1:0] o_min_period,
  output logic [W-1:0] o_max_period,
`endif
  output logic         o_measuring
);

  localparam logic [W-1:0] MAX_W = W'(MAX_COUNT);

  state_t       state_q, state_n;
  logic [W-1:0] count_q, count_n;
  logic [W-1:0] period_n;
  logic         valid_n, timeout_n;
  logic         edge_det;
  logic         level_unused;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_toggle (i_toggle),
    .o_level  (level_unused),
    .o_edge   (edge_det)
  );

  // An edge coinciding with the limit is reported as a period, not a timeout.
  always_comb begin
    state_n   = state_q;
    count_n   = count_q;
    period_n  = o_period;
    valid_n   = 1'b0;
    timeout_n = 1'b0;
    if (!i_enable) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_n = ARMED;
          count_n = '0;
        end
        ARMED: begin
          if (edge_det) begin
            state_n = MEASURE;
            count_n = W'(1);
          end
        end
        MEASURE: begin
          if (edge_det) begin
            period_n = count_q;
            valid_n  = 1'b1;
            count_n  = W'(1);
          end else if (count_q == MAX_W) begin
            timeout_n = 1'b1;
            count_n   = '0;
            state_n   = ARMED;
          end else begin
            count_n = count_q + W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_n;
      count_q   <= count_n;
      o_period  <= period_n;
      o_valid   <= valid_n;
      o_timeout <= timeout_n;
    end
  end

  assign o_measuring = (state_q == MEASURE);

`ifdef TOGGLE_PERIOD_METER_MINMAX_EN
  // Extremes restart on every fresh enable so each session is tracked alone.
  logic enable_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      enable_q     <= 1'b0;
      o_min_period <= '1;
      o_max_period <= '0;
    end else begin
      enable_q <= i_enable;
      if (i_enable && !enable_q) begin
        o_min_period <= '1;
        o_max_period <= '0;
      end else if (valid_n) begin
        if (period_n < o_min_period) o_min_period <= period_n;
        if (period_n > o_max_period) o_max_period <= period_n;
      end
    end
  end
`endif

endmodule
